// File: rtl/axis_tx_arb.sv
// Packet-level arbiter sharing one AXIS TX stream between two sources.
// Grants whole packets (round-robin or port-0 strict) and counts completed packets per port.
module axis_tx_arb #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_en,
  input  logic              cfg_prio,

  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic [KEEP_W-1:0] s0_axis_tkeep,
  input  logic              s0_axis_tlast,

  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic [KEEP_W-1:0] s1_axis_tkeep,
  input  logic              s1_axis_tlast,

  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,

  output logic [1:0]        o_grant,
  output logic [CNT_W-1:0]  o_pkt_cnt0,
  output logic [CNT_W-1:0]  o_pkt_cnt1
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic cand0, cand1, pkt_end, arb_ptr, win0, win1;

  // The grant register alone steers the datapath, so reset idles the output at once.
  always_comb begin
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (grant_q[0]) begin
      m_axis_tvalid  = s0_axis_tvalid;
      m_axis_tdata   = s0_axis_tdata;
      m_axis_tkeep   = s0_axis_tkeep;
      m_axis_tlast   = s0_axis_tlast;
      s0_axis_tready = m_axis_tready;
    end else if (grant_q[1]) begin
      m_axis_tvalid  = s1_axis_tvalid;
      m_axis_tdata   = s1_axis_tdata;
      m_axis_tkeep   = s1_axis_tkeep;
      m_axis_tlast   = s1_axis_tlast;
      s1_axis_tready = m_axis_tready;
    end
  end

  assign cand0   = s0_axis_tvalid & cfg_en[0];
  assign cand1   = s1_axis_tvalid & cfg_en[1];
  assign pkt_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // A port finishing a packet this cycle already counts as last served for the tie-break.
  assign arb_ptr = pkt_end ? grant_q[1] : last_q;
  assign win1    = cand1 & (~cand0 | (~cfg_prio & ~arb_ptr));
  assign win0    = cand0 & ~win1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      IDLE: begin
        if (cand0 | cand1) begin
          state_d = BUSY;
          grant_d = {win1, win0};
        end
      end
      BUSY: begin
        if (pkt_end) begin
          last_d = grant_q[1];
          if (grant_q[0]) cnt0_d = cnt0_q + 1'b1;
          else            cnt1_d = cnt1_q + 1'b1;
          if (cand0 | cand1) begin
            grant_d = {win1, win0};
          end else begin
            state_d = IDLE;
            grant_d = 2'b00;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_pkt_cnt0 = cnt0_q;
  assign o_pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_axis_tx_arb.sv
// Self-checking bench for axis_tx_arb: arbitration vector table plus scoreboarded
// packet streams covering round-robin, priority, backpressure, enable drop, wrap and async reset.
module tb_axis_tx_arb;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [1:0]    cfg_en;
  logic          cfg_prio;
  logic          s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic [DW-1:0] s0_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep;
  logic          s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic [DW-1:0] s1_axis_tdata;
  logic [KW-1:0] s1_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [1:0]    o_grant;
  logic [CW-1:0] o_pkt_cnt0, o_pkt_cnt1;

  axis_tx_arb #(.DATA_W(DW), .KEEP_W(KW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_prio(cfg_prio),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tlast(s0_axis_tlast),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tlast(s1_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .o_grant(o_grant), .o_pkt_cnt0(o_pkt_cnt0), .o_pkt_cnt1(o_pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic       prio;
    logic [1:0] en;
    logic       v0;
    logic       v1;
    logic [1:0] expGrant;
  } vec_t;

  beat_t srcq0[$], srcq1[$], expq0[$], expq1[$];
  int    pktOrder[$];
  vec_t  vecs[8];

  int compared = 0;
  int mismatched = 0;
  int beatCount, idleCount, curOwner, pktId0, pktId1, readyMode;
  bit hs0, hs1;
  logic [DW-1:0] patA, patB;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic loadPacket(input int port, input int nbeats);
    beat_t b;
    int id;
    id = (port == 0) ? pktId0 : pktId1;
    for (int i = 0; i < nbeats; i++) begin
      b.data = '0;
      b.data[DW-1 -: 8] = 8'(8'hA0 + port);
      b.data[31:0] = {8'(port), 8'(id), 16'(i)};
      b.last = (i == nbeats - 1);
      b.keep = {KW{1'b1}} >> (b.last ? (id % 8) : 0);
      if (port == 0) begin srcq0.push_back(b); expq0.push_back(b); end
      else           begin srcq1.push_back(b); expq1.push_back(b); end
    end
    if (port == 0) pktId0++; else pktId1++;
  endtask

  task automatic applyStimulus();
    beat_t b;
    if (hs0 && srcq0.size() > 0) b = srcq0.pop_front();
    if (hs1 && srcq1.size() > 0) b = srcq1.pop_front();
    hs0 = 1'b0;
    hs1 = 1'b0;
    case (readyMode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'b0;
    endcase
    if (srcq0.size() > 0) begin
      b = srcq0[0];
      s0_axis_tvalid = 1'b1; s0_axis_tdata = b.data; s0_axis_tkeep = b.keep; s0_axis_tlast = b.last;
    end else begin
      s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tlast = 1'b0;
    end
    if (srcq1.size() > 0) begin
      b = srcq1[0];
      s1_axis_tvalid = 1'b1; s1_axis_tdata = b.data; s1_axis_tkeep = b.keep; s1_axis_tlast = b.last;
    end else begin
      s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tlast = 1'b0;
    end
  endtask

  // Sampled mid-cycle: any beat seen here transfers at the next rising edge.
  task automatic monitorSample();
    beat_t e;
    int p;
    hs0 = s0_axis_tvalid && s0_axis_tready;
    hs1 = s1_axis_tvalid && s1_axis_tready;
    if (!m_axis_tvalid) idleCount++;
    if (m_axis_tvalid && m_axis_tready) begin
      p = (o_grant == 2'b01) ? 0 : ((o_grant == 2'b10) ? 1 : -1);
      if (p < 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL grant_onehot: got %b required one-hot during beat", o_grant);
      end else if ((p == 0 && expq0.size() == 0) || (p == 1 && expq1.size() == 0)) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_beat: port %0d beat %0h, none outstanding", p, m_axis_tdata);
      end else begin
        e = (p == 0) ? expq0.pop_front() : expq1.pop_front();
        checkOutput("beat_data", m_axis_tdata, e.data);
        checkOutput("beat_keep", DW'(m_axis_tkeep), DW'(e.keep));
        checkOutput("beat_last", DW'(m_axis_tlast), DW'(e.last));
        checkOutput("other_tready", DW'((p == 0) ? s1_axis_tready : s0_axis_tready), DW'(0));
        if (curOwner >= 0) checkOutput("no_interleave", DW'(p), DW'(curOwner));
        if (e.last) begin
          curOwner = -1;
          pktOrder.push_back(p);
        end else begin
          curOwner = p;
        end
        beatCount++;
      end
    end
  endtask

  task automatic runCycle();
    @(negedge clk);
    monitorSample();
    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  task automatic runUntilBeats(input int target, input int budget);
    int n = 0;
    while (beatCount < target && n < budget) begin
      runCycle();
      n++;
    end
    checkOutput("beats_reached", DW'(beatCount), DW'(target));
  endtask

  task automatic doReset();
    rst = 1'b0;
    srcq0.delete(); srcq1.delete(); expq0.delete(); expq1.delete(); pktOrder.delete();
    hs0 = 1'b0; hs1 = 1'b0; curOwner = -1; beatCount = 0; idleCount = 0; readyMode = 0;
    cfg_en = 2'b11; cfg_prio = 1'b0;
    s0_axis_tvalid = 1'b1; s0_axis_tlast = 1'b1; s0_axis_tdata = patA; s0_axis_tkeep = '1;
    s1_axis_tvalid = 1'b1; s1_axis_tlast = 1'b1; s1_axis_tdata = patB; s1_axis_tkeep = '1;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    checkOutput("rst_grant", DW'(o_grant), DW'(0));
    checkOutput("rst_s0_tready", DW'(s0_axis_tready), DW'(0));
    checkOutput("rst_s1_tready", DW'(s1_axis_tready), DW'(0));
    checkOutput("rst_cnt0", DW'(o_pkt_cnt0), DW'(0));
    checkOutput("rst_cnt1", DW'(o_pkt_cnt1), DW'(0));
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tlast = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tlast = 1'b0;
  endtask

  task automatic releaseReset();
    applyStimulus();
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s1ReadyCount;
    patA = '0; patA[DW-1 -: 16] = 16'hAAAA; patA[15:0] = 16'h1234;
    patB = '0; patB[DW-1 -: 16] = 16'hBBBB; patB[15:0] = 16'h5678;
    pktId0 = 0; pktId1 = 0;

    vecs[0] = '{prio: 1'b0, en: 2'b11, v0: 1'b1, v1: 1'b1, expGrant: 2'b01};
    vecs[1] = '{prio: 1'b0, en: 2'b11, v0: 1'b0, v1: 1'b1, expGrant: 2'b10};
    vecs[2] = '{prio: 1'b0, en: 2'b01, v0: 1'b1, v1: 1'b1, expGrant: 2'b01};
    vecs[3] = '{prio: 1'b0, en: 2'b10, v0: 1'b1, v1: 1'b1, expGrant: 2'b10};
    vecs[4] = '{prio: 1'b1, en: 2'b11, v0: 1'b1, v1: 1'b1, expGrant: 2'b01};
    vecs[5] = '{prio: 1'b1, en: 2'b10, v0: 1'b1, v1: 1'b1, expGrant: 2'b10};
    vecs[6] = '{prio: 1'b0, en: 2'b00, v0: 1'b1, v1: 1'b1, expGrant: 2'b00};
    vecs[7] = '{prio: 1'b1, en: 2'b11, v0: 1'b0, v1: 1'b0, expGrant: 2'b00};

    doReset();

    // First arbitration out of reset for each vector; tready held low so nothing completes.
    for (int i = 0; i < 8; i++) begin
      rst = 1'b0;
      #1;
      cfg_prio = vecs[i].prio; cfg_en = vecs[i].en; m_axis_tready = 1'b0;
      s0_axis_tvalid = vecs[i].v0; s0_axis_tdata = patA; s0_axis_tlast = 1'b1;
      s1_axis_tvalid = vecs[i].v1; s1_axis_tdata = patB; s1_axis_tlast = 1'b1;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("vec_grant", DW'(o_grant), DW'(vecs[i].expGrant));
      checkOutput("vec_m_tvalid", DW'(m_axis_tvalid), DW'(vecs[i].expGrant != 2'b00));
      checkOutput("vec_m_tdata", m_axis_tdata,
                  (vecs[i].expGrant == 2'b01) ? patA : ((vecs[i].expGrant == 2'b10) ? patB : '0));
    end

    $display("[TB] round-robin streaming");
    doReset();
    for (int i = 0; i < 5; i++) begin
      loadPacket(0, 4);
      loadPacket(1, 4);
    end
    releaseReset();
    runUntilBeats(40, 200);
    checkOutput("rr_idle_cycles", DW'(idleCount), DW'(1));
    checkOutput("rr_cnt0", DW'(o_pkt_cnt0), DW'(5));
    checkOutput("rr_cnt1", DW'(o_pkt_cnt1), DW'(5));
    checkOutput("rr_pkts", DW'(pktOrder.size()), DW'(10));
    for (int i = 0; i < pktOrder.size(); i++) checkOutput("rr_order", DW'(pktOrder[i]), DW'(i % 2));

    $display("[TB] port 0 strict priority");
    doReset();
    cfg_prio = 1'b1;
    for (int i = 0; i < 3; i++) begin
      loadPacket(0, 4);
      loadPacket(1, 4);
    end
    releaseReset();
    s1ReadyCount = 0;
    for (int i = 0; i < 30; i++) begin
      runCycle();
      if (s1_axis_tready) s1ReadyCount++;
    end
    checkOutput("prio_s1_tready", DW'(s1ReadyCount), DW'(0));
    checkOutput("prio_beats", DW'(beatCount), DW'(12));
    checkOutput("prio_cnt0", DW'(o_pkt_cnt0), DW'(3));
    checkOutput("prio_cnt1", DW'(o_pkt_cnt1), DW'(0));

    $display("[TB] backpressure during long port 1 packet");
    doReset();
    readyMode = 1;
    loadPacket(1, 512);
    releaseReset();
    repeat (3) runCycle();
    checkOutput("bp_grant", DW'(o_grant), DW'(2'b10));
    loadPacket(0, 4);
    runUntilBeats(516, 3000);
    checkOutput("bp_pkts", DW'(pktOrder.size()), DW'(2));
    if (pktOrder.size() >= 2) begin
      checkOutput("bp_first_pkt", DW'(pktOrder[0]), DW'(1));
      checkOutput("bp_second_pkt", DW'(pktOrder[1]), DW'(0));
    end
    checkOutput("bp_cnt0", DW'(o_pkt_cnt0), DW'(1));
    checkOutput("bp_cnt1", DW'(o_pkt_cnt1), DW'(1));

    $display("[TB] enable dropped mid-packet");
    doReset();
    cfg_en = 2'b10;
    loadPacket(1, 8);
    releaseReset();
    runUntilBeats(3, 50);
    cfg_en = 2'b00;
    runUntilBeats(8, 50);
    checkOutput("en_grant_idle", DW'(o_grant), DW'(0));
    checkOutput("en_cnt1", DW'(o_pkt_cnt1), DW'(1));
    loadPacket(1, 4);
    repeat (20) runCycle();
    checkOutput("en_no_new_beats", DW'(beatCount), DW'(8));
    checkOutput("en_no_new_grant", DW'(o_grant), DW'(0));
    checkOutput("en_s1_tready", DW'(s1_axis_tready), DW'(0));

    $display("[TB] counter wrap and async reset");
    doReset();
    for (int i = 0; i < 17; i++) loadPacket(0, 1);
    releaseReset();
    runUntilBeats(17, 100);
    checkOutput("wrap_cnt0", DW'(o_pkt_cnt0), DW'(1));
    loadPacket(0, 4);
    runUntilBeats(19, 50);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    checkOutput("arst_m_tdata", m_axis_tdata, '0);
    checkOutput("arst_grant", DW'(o_grant), DW'(0));
    checkOutput("arst_s0_tready", DW'(s0_axis_tready), DW'(0));
    checkOutput("arst_cnt0", DW'(o_pkt_cnt0), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
